rs_issue_scheduler: RTL and testbench

//  Issue scheduler between the reservation station and the ALU bank.
//  - Each cycle selects up to ALU_NUM ready station entries and binds each to a free ALU.
//  - Tracks entry age and ALU busy state.
//  - Retires ALU occupancy on the per-ALU Comp completion pulses.
//  - Drives registered grants back to the station (entry release) and start strobes to the ALUs.

---
 rtl/rs_sched_pkg.sv | 23 ++
 rtl/rs_issue_scheduler_if.sv | 25 ++
 rtl/rs_oldest_picker.sv | 45 ++++
 rtl/rs_issue_scheduler.sv | 97 +++++++++
 tb/tb_rs_issue_scheduler.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/rs_sched_pkg.sv
// rtl/rs_sched_pkg.sv - shared sizes, types and helpers for the RS issue scheduler
package rs_sched_pkg;

    localparam int RS_ROWS    = 8;
    localparam int ALU_NUM    = 3;
    localparam int ALUOP_BITS = 3;
    localparam int ENTRY_W    = $clog2(RS_ROWS);

    typedef logic [ENTRY_W-1:0]    entry_idx_t;
    typedef logic [ALUOP_BITS-1:0] aluop_t;
    typedef logic [ALU_NUM-1:0]    alu_vec_t;
    typedef logic [RS_ROWS-1:0]    row_vec_t;

    function automatic entry_idx_t onehot_to_idx(row_vec_t v);
        entry_idx_t idx;
        idx = '0;
        for (int i = 0; i < RS_ROWS; i++) begin
            if (v[i]) idx = idx | entry_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rs_issue_scheduler_if.sv
// rtl/rs_issue_scheduler_if.sv - station/ALU-side signal bundle of the issue scheduler
interface rs_issue_scheduler_if;
    import rs_sched_pkg::*;

    row_vec_t                  entry_alloc;
    row_vec_t                  entry_ready;
    aluop_t [RS_ROWS-1:0]      entry_aluop;
    alu_vec_t                  Comp;
    row_vec_t                  issue_grant;
    alu_vec_t                  alu_start;
    entry_idx_t [ALU_NUM-1:0]  alu_entry;
    aluop_t [ALU_NUM-1:0]      alu_op;
    alu_vec_t                  alu_busy;

    modport master (
        output entry_alloc, entry_ready, entry_aluop, Comp,
        input  issue_grant, alu_start, alu_entry, alu_op, alu_busy
    );

    modport slave (
        input  entry_alloc, entry_ready, entry_aluop, Comp,
        output issue_grant, alu_start, alu_entry, alu_op, alu_busy
    );

endinterface

// File: rtl/rs_oldest_picker.sv
// rtl/rs_oldest_picker.sv - one-hot pick of the highest-priority unexcluded candidate
// RS_AGE_ORDER_EN selects oldest-first via the age matrix, else lowest index first.
module rs_oldest_picker
    import rs_sched_pkg::*;
(
    input  row_vec_t                      cand,
    input  row_vec_t                      excl,
`ifdef RS_AGE_ORDER_EN
    input  logic [RS_ROWS-1:0][RS_ROWS-1:0] age,
`endif
    output row_vec_t                      pick
);

    row_vec_t avail;
    assign avail = cand & ~excl;

`ifdef RS_AGE_ORDER_EN
    // Pairs never ordered by an allocation (both bits 0) fall back to index order.
    always_comb begin
        pick = '0;
        for (int i = 0; i < RS_ROWS; i++) begin
            if (avail[i]) begin
                pick[i] = 1'b1;
                for (int j = 0; j < RS_ROWS; j++) begin
                    if (j != i && avail[j] && !(age[i][j] || (!age[j][i] && i < j)))
                        pick[i] = 1'b0;
                end
            end
        end
    end
`else
    logic found;
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < RS_ROWS; i++) begin
            if (avail[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/rs_issue_scheduler.sv
// rtl/rs_issue_scheduler.sv - binds ready station entries to free ALUs with registered grants
// RS_ROWS-square age matrix and oldest-first priority are built only with RS_AGE_ORDER_EN.
module rs_issue_scheduler
    import rs_sched_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    rs_issue_scheduler_if.slave bus
);

    alu_vec_t                     busy;
    alu_vec_t                     free;
    alu_vec_t                     take;
    row_vec_t                     issued;
    row_vec_t                     cand;
    logic [ALU_NUM:0][RS_ROWS-1:0] excl;
    logic [ALU_NUM-1:0][RS_ROWS-1:0] pick;
    entry_idx_t [ALU_NUM-1:0]     entry_next;
    aluop_t [ALU_NUM-1:0]         op_next;

    row_vec_t                     grant_q;
    alu_vec_t                     start_q;
    entry_idx_t [ALU_NUM-1:0]     entry_q;
    aluop_t [ALU_NUM-1:0]         op_q;

    assign cand    = bus.entry_ready & ~issued & ~bus.entry_alloc;
    assign free    = ~busy | bus.Comp;
    assign excl[0] = '0;

`ifdef RS_AGE_ORDER_EN
    // age[i][j] = 1 means entry i is older than entry j.
    logic [RS_ROWS-1:0][RS_ROWS-1:0] age;

    always_ff @(posedge clk) begin
        if (rst) begin
            age <= '0;
        end else begin
            for (int i = 0; i < RS_ROWS; i++) begin
                for (int j = 0; j < RS_ROWS; j++) begin
                    if (i != j) begin
                        if (bus.entry_alloc[i] && bus.entry_alloc[j]) age[i][j] <= (i < j);
                        else if (bus.entry_alloc[i])                 age[i][j] <= 1'b0;
                        else if (bus.entry_alloc[j])                 age[i][j] <= 1'b1;
                    end
                end
            end
        end
    end
`endif

    // Each ALU stage excludes the entries already taken by lower-numbered ALUs.
    for (genvar k = 0; k < ALU_NUM; k++) begin : g_alu
`ifdef RS_AGE_ORDER_EN
        rs_oldest_picker u_pick (.cand(cand), .excl(excl[k]), .age(age), .pick(pick[k]));
`else
        rs_oldest_picker u_pick (.cand(cand), .excl(excl[k]), .pick(pick[k]));
`endif
        assign take[k]     = free[k] & (|pick[k]);
        assign excl[k+1]   = excl[k] | (take[k] ? pick[k] : '0);
    end

    always_comb begin
        entry_next = entry_q;
        op_next    = op_q;
        for (int k = 0; k < ALU_NUM; k++) begin
            if (take[k]) begin
                entry_next[k] = onehot_to_idx(pick[k]);
                op_next[k]    = bus.entry_aluop[entry_next[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= '0;
            issued  <= '0;
            grant_q <= '0;
            start_q <= '0;
            entry_q <= '0;
            op_q    <= '0;
        end else begin
            busy    <= (busy & ~bus.Comp) | take;
            issued  <= (issued | excl[ALU_NUM]) & ~bus.entry_alloc;
            grant_q <= excl[ALU_NUM];
            start_q <= take;
            entry_q <= entry_next;
            op_q    <= op_next;
        end
    end

    assign bus.issue_grant = grant_q;
    assign bus.alu_start   = start_q;
    assign bus.alu_entry   = entry_q;
    assign bus.alu_op      = op_q;
    assign bus.alu_busy    = busy;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb/tb_rs_issue_scheduler.sv - scoreboard bench for rs_issue_scheduler (honours RS_AGE_ORDER_EN)
module tb_rs_issue_scheduler;
    import rs_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs_issue_scheduler_if sif ();

    rs_issue_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    typedef struct packed {
        row_vec_t                          grant;
        alu_vec_t                          start;
        alu_vec_t                          busy;
        logic [ALU_NUM-1:0][ENTRY_W-1:0]   entry;
        logic [ALU_NUM-1:0][ALUOP_BITS-1:0] op;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: busy flags, issued flags, allocation timestamps.
    bit                                 m_busy   [ALU_NUM];
    bit                                 m_issued [RS_ROWS];
    int                                 m_stamp  [RS_ROWS];
    int                                 m_clock;
    logic [ALU_NUM-1:0][ENTRY_W-1:0]    m_entry;
    logic [ALU_NUM-1:0][ALUOP_BITS-1:0] m_op;

    function automatic int prio_key(int i);
`ifdef RS_AGE_ORDER_EN
        return m_stamp[i] * RS_ROWS + i;
`else
        return i;
`endif
    endfunction

    task automatic drive(input bit r, input row_vec_t alloc, input row_vec_t ready,
                         input logic [RS_ROWS-1:0][ALUOP_BITS-1:0] ops, input alu_vec_t comp);
        exp_t e;
        bit   taken [RS_ROWS];
        int   best;
        @(negedge clk);
        rst             = r;
        sif.entry_alloc = alloc;
        sif.entry_ready = ready;
        sif.entry_aluop = ops;
        sif.Comp        = comp;
        e = '0;
        if (r) begin
            for (int k = 0; k < ALU_NUM; k++) m_busy[k] = 1'b0;
            for (int i = 0; i < RS_ROWS; i++) begin
                m_issued[i] = 1'b0;
                m_stamp[i]  = 0;
            end
            m_clock = 1;
            m_entry = '0;
            m_op    = '0;
        end else begin
            for (int i = 0; i < RS_ROWS; i++) taken[i] = 1'b0;
            for (int k = 0; k < ALU_NUM; k++) begin
                best = -1;
                if (!m_busy[k] || comp[k]) begin
                    for (int i = 0; i < RS_ROWS; i++) begin
                        if (ready[i] && !m_issued[i] && !alloc[i] && !taken[i])
                            if (best < 0 || prio_key(i) < prio_key(best)) best = i;
                    end
                end
                if (best >= 0) begin
                    taken[best]    = 1'b1;
                    e.grant[best]  = 1'b1;
                    e.start[k]     = 1'b1;
                    m_busy[k]      = 1'b1;
                    m_entry[k]     = best[ENTRY_W-1:0];
                    m_op[k]        = ops[best];
                end else if (comp[k]) begin
                    m_busy[k] = 1'b0;
                end
            end
            for (int i = 0; i < RS_ROWS; i++) begin
                if (alloc[i])      m_issued[i] = 1'b0;
                else if (taken[i]) m_issued[i] = 1'b1;
            end
            for (int i = 0; i < RS_ROWS; i++) begin
                if (alloc[i]) begin
                    m_stamp[i] = m_clock;
                    m_clock++;
                end
            end
        end
        for (int k = 0; k < ALU_NUM; k++) e.busy[k] = m_busy[k];
        e.entry = m_entry;
        e.op    = m_op;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue_grant", 64'(sif.issue_grant), 64'(e.grant));
            chk("alu_start",   64'(sif.alu_start),   64'(e.start));
            chk("alu_busy",    64'(sif.alu_busy),    64'(e.busy));
            chk("alu_entry",   64'(sif.alu_entry),   64'(e.entry));
            chk("alu_op",      64'(sif.alu_op),      64'(e.op));
        end
    end

    logic [RS_ROWS-1:0][ALUOP_BITS-1:0] ops_v;
    row_vec_t                           ra, rr;
    alu_vec_t                           rc;

    initial begin
        ops_v = '0;
        // reset with everything ready, then two fresh entries issued together
        drive(1, 8'h00, 8'hFF, ops_v, 3'b000);
        drive(1, 8'h00, 8'hFF, ops_v, 3'b000);
        drive(0, 8'h03, 8'h00, ops_v, 3'b000);
        drive(0, 8'h00, 8'h03, ops_v, 3'b000);
        drive(0, 8'h00, 8'h00, ops_v, 3'b000);
        drive(0, 8'h00, 8'h00, ops_v, 3'b011);
        // five ready entries against three ALUs, back-to-back refill on Comp
        ops_v = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        drive(0, 8'h7C, 8'h00, ops_v, 3'b000);
        drive(0, 8'h00, 8'h7C, ops_v, 3'b000);
        drive(0, 8'h00, 8'h7C, ops_v, 3'b000);
        drive(0, 8'h00, 8'h7C, ops_v, 3'b100);
        drive(0, 8'h00, 8'h7C, ops_v, 3'b000);
        drive(0, 8'h00, 8'h7C, ops_v, 3'b001);
        drive(0, 8'h00, 8'h00, ops_v, 3'b111);
        // alloc and ready in the same cycle
        drive(0, 8'h08, 8'h08, ops_v, 3'b000);
        drive(0, 8'h00, 8'h08, ops_v, 3'b000);
        drive(0, 8'h00, 8'h00, ops_v, 3'b111);
        // entry 5 allocated before entry 2, single free ALU
        drive(0, 8'h20, 8'h00, ops_v, 3'b000);
        drive(0, 8'h04, 8'h00, ops_v, 3'b000);
        drive(0, 8'h03, 8'h00, ops_v, 3'b000);
        drive(0, 8'h00, 8'h03, ops_v, 3'b000);
        drive(0, 8'h00, 8'h24, ops_v, 3'b000);
        drive(0, 8'h00, 8'h24, ops_v, 3'b100);
        drive(0, 8'h00, 8'h00, ops_v, 3'b111);
        // reset while all ALUs are busy, then stale Comp pulses
        drive(0, 8'h07, 8'h00, ops_v, 3'b000);
        drive(0, 8'h00, 8'h07, ops_v, 3'b000);
        drive(0, 8'h00, 8'h00, ops_v, 3'b000);
        drive(1, 8'h00, 8'h00, ops_v, 3'b000);
        drive(0, 8'h00, 8'h00, ops_v, 3'b111);
        drive(0, 8'h00, 8'h00, ops_v, 3'b000);
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < RS_ROWS; i++) begin
                ra[i]    = ($urandom_range(0, 7) == 0);
                rr[i]    = ($urandom_range(0, 1) == 1);
                ops_v[i] = ALUOP_BITS'($urandom);
            end
            for (int k = 0; k < ALU_NUM; k++) rc[k] = ($urandom_range(0, 2) == 0);
            drive(($urandom_range(0, 199) == 0), ra, rr, ops_v, rc);
        end
        drive(0, 8'h00, 8'h00, ops_v, 3'b000);
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
